mips_multicycle_ctrl: RTL and testbench

//  Multicycle MIPS control FSM; drives alu_control/select lines into the registered ALU and consumes its zero_flag.
//  ALU result and zero_flag appear 1 cycle after alu_control is issued; every FSM step accounts for that latency.

---
 rtl/mips_ctrl_pkg.sv | 49 ++++
 rtl/mips_multicycle_ctrl_alu_op_decoder.sv | 45 ++++
 rtl/mips_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Purpose: shared ALU codes, opcode/funct constants, FSM state and mux-select enums for the multicycle controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a. IMM states exist only when MIPS_CTRL_IMM_EN is defined.
package mips_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_MEM_ADR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR,
    ST_EXEC, ST_ALU_WB, ST_BR_CMP, ST_BR_TGT, ST_BR_WR, ST_JUMP
`ifdef MIPS_CTRL_IMM_EN
    , ST_IMM_EXEC, ST_IMM_WB
`endif
  } state_e;

  typedef enum logic [1:0] {SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} alu_src_b_e;
  typedef enum logic {PC_SRC_ALU, PC_SRC_JUMP} pc_src_e;

  // How the ALU operation is chosen in the current state
  typedef enum logic [1:0] {ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_FUNCT, ALU_CLS_IMM} alu_cls_e;

  // Logical immediates are zero-extended, arithmetic ones sign-extended
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_op_decoder.sv
// Purpose: maps state class plus opcode/funct to the 4-bit ALU operation and a legality flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; unknown funct/opcode yields legal=0 and the AND code (0000).
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_cls_e    alu_cls,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_control,
  output logic        legal
);

  // Select the ALU operation for the requested class
  always_comb begin
    alu_control = ALU_AND;
    legal       = 1'b1;
    case (alu_cls)
      ALU_CLS_ADD: alu_control = ALU_ADD;
      ALU_CLS_SUB: alu_control = ALU_SUB;
      ALU_CLS_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_SLT: alu_control = ALU_SLT;
          FUNCT_NOR: alu_control = ALU_NOR;
          default:   legal       = 1'b0;
        endcase
      end
      ALU_CLS_IMM: begin
        case (opcode)
          OP_ADDI: alu_control = ALU_ADD;
          OP_SLTI: alu_control = ALU_SLT;
          OP_ANDI: alu_control = ALU_AND;
          OP_ORI:  alu_control = ALU_OR;
          default: legal       = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Purpose: multicycle MIPS control FSM (fetch/decode/mem/exec/branch/jump); MIPS_CTRL_IMM_EN adds ADDI/SLTI/ANDI/ORI.
// Latency: LW 5, SW 4, R 4, BEQ 5, J 3 cycles with immediate mem_ready; ALU results used one cycle after issue.
// Backpressure: mem_req held until mem_ready; optional MEM_WAIT_MAX bound pulses mem_timeout and returns to FETCH.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic [3:0]  alu_control,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        imm_zext,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal_instr,
  output logic        mem_timeout
);

  localparam int unsigned CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_WAIT_MAX);

  state_e          state_q, state_d;
  logic            branch_taken_q, branch_taken_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  alu_cls_e        alu_cls;
  logic [3:0]      dec_ctrl;
  logic            dec_legal;
  logic            wait_expired;
  logic            in_access;
  logic            acc_we;
  state_e          acc_next;

  alu_op_decoder u_alu_op_decoder (
    .alu_cls     (alu_cls),
    .opcode      (opcode),
    .funct       (funct),
    .alu_control (dec_ctrl),
    .legal       (dec_legal)
  );

  // Completion in the same cycle as the limit wins, so expiry requires mem_ready low
  assign wait_expired = (MEM_WAIT_MAX != 0) && (wait_cnt_q == WAIT_MAX) && !mem_ready;

  // State, branch decision and memory wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RST;
      branch_taken_q <= 1'b0;
      wait_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      branch_taken_q <= branch_taken_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  // ALU operation class per state; kept apart so the decoder is not in a loop with the main FSM block
  always_comb begin
    alu_cls = ALU_CLS_ADD;
    case (state_q)
      ST_EXEC:     alu_cls = ALU_CLS_FUNCT;
      ST_BR_CMP:   alu_cls = ALU_CLS_SUB;
`ifdef MIPS_CTRL_IMM_EN
      ST_IMM_EXEC: alu_cls = ALU_CLS_IMM;
`endif
      default:     alu_cls = ALU_CLS_ADD;
    endcase
  end

  // Next-state and Moore outputs; memory states share one wait/timeout handler below the case
  always_comb begin
    state_d        = state_q;
    branch_taken_d = branch_taken_q;
    wait_cnt_d     = '0;
    in_access      = 1'b0;
    acc_we         = 1'b0;
    acc_next       = ST_FETCH;
    alu_control    = 4'b0000;
    alu_src_a      = 1'b0;
    alu_src_b      = SRCB_REG;
    imm_zext       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = PC_SRC_ALU;
    ir_write       = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    iord           = 1'b0;
    reg_write      = 1'b0;
    reg_dst        = 1'b0;
    mem_to_reg     = 1'b0;
    illegal_instr  = 1'b0;
    mem_timeout    = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        alu_control = dec_ctrl;
        alu_src_b   = SRCB_FOUR;
        ir_write    = mem_ready;
        in_access   = 1'b1;
        acc_next    = ST_DECODE;
      end
      ST_DECODE: begin
        // PC+4 was computed by the ALU during FETCH
        pc_write = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADR;
          OP_R:         state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BR_CMP;
          OP_J:         state_d = ST_JUMP;
`ifdef MIPS_CTRL_IMM_EN
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = ST_IMM_EXEC;
`endif
          default: begin
            illegal_instr = 1'b1;
            state_d       = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADR: begin
        alu_control = dec_ctrl;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        state_d     = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        iord      = 1'b1;
        in_access = 1'b1;
        acc_next  = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        iord      = 1'b1;
        in_access = 1'b1;
        acc_we    = 1'b1;
        acc_next  = ST_FETCH;
      end
      ST_EXEC: begin
        alu_control = dec_ctrl;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_REG;
        if (dec_legal) begin
          state_d = ST_ALU_WB;
        end else begin
          illegal_instr = 1'b1;
          state_d       = ST_FETCH;
        end
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BR_CMP: begin
        alu_control = dec_ctrl;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_REG;
        state_d     = ST_BR_TGT;
      end
      ST_BR_TGT: begin
        // zero_flag now reflects the A-B issued in BR_CMP; the target add issues now
        alu_control    = dec_ctrl;
        alu_src_b      = SRCB_IMM_SH2;
        branch_taken_d = zero_flag;
        state_d        = ST_BR_WR;
      end
      ST_BR_WR: begin
        pc_write = branch_taken_q;
        state_d  = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
        state_d  = ST_FETCH;
      end
`ifdef MIPS_CTRL_IMM_EN
      ST_IMM_EXEC: begin
        alu_control = dec_ctrl;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        imm_zext    = is_zext_op(opcode);
        state_d     = ST_IMM_WB;
      end
      ST_IMM_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
`endif
      default: state_d = ST_FETCH;
    endcase

    // Shared memory handshake: counter restarts on every entry because it clears on any exit
    if (in_access) begin
      if (mem_ready) begin
        mem_req = 1'b1;
        state_d = acc_next;
      end else if (wait_expired) begin
        mem_timeout = 1'b1;
        state_d     = ST_FETCH;
      end else begin
        mem_req    = 1'b1;
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
    mem_we = acc_we && mem_req;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose: randomized and directed bench for mips_multicycle_ctrl against a per-instruction output-sequence model.
// Latency: model expands each instruction into its expected cycle sequence; outputs compared every cycle.
// Backpressure: mem_ready delays, including timeout and ready-at-limit, drawn per access; MEM_WAIT_MAX fixed to 8.
module tb_mips_multicycle_ctrl;

  localparam int WMAX = 8;
`ifdef MIPS_CTRL_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111, A_NOR = 4'b1100;
  localparam logic [5:0] O_R = 6'b000000, O_J = 6'b000010, O_BEQ = 6'b000100;
  localparam logic [5:0] O_LW = 6'b100011, O_SW = 6'b101011;
  localparam logic [5:0] O_ADDI = 6'b001000, O_SLTI = 6'b001010, O_ANDI = 6'b001100, O_ORI = 6'b001101;

  typedef logic [18:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero_flag, mem_ready;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext, pc_write, pc_src, ir_write, mem_req, mem_we, iord;
  logic       reg_write, reg_dst, mem_to_reg, illegal_instr, mem_timeout;
  vec_t       obs;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  vec_t exp_q[$];
  bit   rdy_q[$];
  bit   zf_q[$];
  int   zf_force = -1;
  logic [5:0] cur_op, cur_fn;
  logic [5:0] legal_fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
  logic [5:0] imm_ops [4] = '{O_ADDI, O_SLTI, O_ANDI, O_ORI};

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_zext(imm_zext), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req),
    .mem_we(mem_we), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_instr(illegal_instr), .mem_timeout(mem_timeout)
  );

  assign obs = {alu_control, alu_src_a, alu_src_b, imm_zext, pc_write, pc_src, ir_write, mem_req,
                mem_we, iord, reg_write, reg_dst, mem_to_reg, illegal_instr, mem_timeout};

  function automatic vec_t ov(logic [3:0] alu, logic a, logic [1:0] b, logic zx, logic pcw, logic pcs,
                              logic irw, logic req, logic we, logic io, logic rw, logic rd, logic m2r,
                              logic ill, logic tmo);
    return {alu, a, b, zx, pcw, pcs, irw, req, we, io, rw, rd, m2r, ill, tmo};
  endfunction

  // R-type table: {legal, alu code}
  function automatic logic [4:0] ref_funct(logic [5:0] fn);
    case (fn)
      6'b100000: return {1'b1, A_ADD};
      6'b100010: return {1'b1, A_SUB};
      6'b100100: return {1'b1, A_AND};
      6'b100101: return {1'b1, A_OR};
      6'b101010: return {1'b1, A_SLT};
      6'b100111: return {1'b1, A_NOR};
      default:   return 5'b0;
    endcase
  endfunction

  // Immediate table: {legal, zext, alu code}
  function automatic logic [5:0] ref_imm(logic [5:0] op);
    case (op)
      O_ADDI:  return {2'b10, A_ADD};
      O_SLTI:  return {2'b10, A_SLT};
      O_ANDI:  return {2'b11, A_AND};
      O_ORI:   return {2'b11, A_OR};
      default: return 6'b0;
    endcase
  endfunction

  task automatic check(string tag, vec_t o, vec_t e);
    n_chk++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic push(vec_t v, bit r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
    zf_q.push_back((zf_force >= 0) ? 1'(zf_force) : 1'($urandom_range(0, 1)));
  endtask

  // One memory access: ready after d wait cycles, unless the limit expires first
  task automatic access(vec_t wait_v, vec_t done_v, vec_t tmo_v, int d, output bit timed_out);
    timed_out = 1'b0;
    for (int w = 0; w <= WMAX; w++) begin
      if (w == d) begin
        push(done_v, 1'b1);
        return;
      end else if (w == WMAX) begin
        push(tmo_v, 1'b0);
        timed_out = 1'b1;
        return;
      end
      push(wait_v, 1'b0);
    end
  endtask

  // Expected per-cycle outputs for one instruction
  task automatic model_instr(logic [5:0] op, logic [5:0] fn, int df, int dm);
    bit to;
    bit ill;
    bit z;
    int d;
    logic [4:0] rf;
    logic [5:0] ri;
    exp_q.delete(); rdy_q.delete(); zf_q.delete();
    d = df;
    do begin
      access(ov(A_ADD,0,1,0, 0,0,0,1,0,0, 0,0,0,0,0), ov(A_ADD,0,1,0, 0,0,1,1,0,0, 0,0,0,0,0),
             ov(A_ADD,0,1,0, 0,0,0,0,0,0, 0,0,0,0,1), d, to);
      d = d - (WMAX + 1);
    end while (to);
    ri  = ref_imm(op);
    ill = !(op == O_LW || op == O_SW || op == O_R || op == O_BEQ || op == O_J || (IMM_EN && ri[5]));
    push(ov(4'b0,0,0,0, 1,0,0,0,0,0, 0,0,0,ill,0), 1'($urandom_range(0, 1)));
    if (ill) return;
    if (op == O_LW || op == O_SW) begin
      bit sw = (op == O_SW);
      push(ov(A_ADD,1,2,0, 0,0,0,0,0,0, 0,0,0,0,0), 1'($urandom_range(0, 1)));
      access(ov(4'b0,0,0,0, 0,0,0,1,sw,1, 0,0,0,0,0), ov(4'b0,0,0,0, 0,0,0,1,sw,1, 0,0,0,0,0),
             ov(4'b0,0,0,0, 0,0,0,0,0,1, 0,0,0,0,1), dm, to);
      if (!sw && !to) push(ov(4'b0,0,0,0, 0,0,0,0,0,0, 1,0,1,0,0), 1'($urandom_range(0, 1)));
    end else if (op == O_R) begin
      rf = ref_funct(fn);
      if (rf[4]) begin
        push(ov(rf[3:0],1,0,0, 0,0,0,0,0,0, 0,0,0,0,0), 1'($urandom_range(0, 1)));
        push(ov(4'b0,0,0,0, 0,0,0,0,0,0, 1,1,0,0,0), 1'($urandom_range(0, 1)));
      end else begin
        push(ov(4'b0,1,0,0, 0,0,0,0,0,0, 0,0,0,1,0), 1'($urandom_range(0, 1)));
      end
    end else if (op == O_BEQ) begin
      push(ov(A_SUB,1,0,0, 0,0,0,0,0,0, 0,0,0,0,0), 1'($urandom_range(0, 1)));
      push(ov(A_ADD,0,3,0, 0,0,0,0,0,0, 0,0,0,0,0), 1'($urandom_range(0, 1)));
      z = zf_q[$];
      push(ov(4'b0,0,0,0, z,0,0,0,0,0, 0,0,0,0,0), 1'($urandom_range(0, 1)));
    end else if (op == O_J) begin
      push(ov(4'b0,0,0,0, 1,1,0,0,0,0, 0,0,0,0,0), 1'($urandom_range(0, 1)));
    end else begin
      push(ov(ri[3:0],1,2,ri[4], 0,0,0,0,0,0, 0,0,0,0,0), 1'($urandom_range(0, 1)));
      push(ov(4'b0,0,0,0, 0,0,0,0,0,0, 1,0,0,0,0), 1'($urandom_range(0, 1)));
    end
  endtask

  // Drive inputs just after each rising edge, compare at the falling edge
  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        opcode = cur_op;
        funct  = cur_fn;
      end
      mem_ready = rdy_q[i];
      zero_flag = zf_q[i];
      @(negedge clk);
      check(tag, obs, exp_q[i]);
    end
  endtask

  task automatic do_instr(string tag, logic [5:0] op, logic [5:0] fn, int df, int dm);
    cur_op = op;
    cur_fn = fn;
    model_instr(op, fn, df, dm);
    run(tag, exp_q.size());
  endtask

  function automatic int pick_delay();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; zero_flag = 1'b0; mem_ready = 1'b0;
    #12;
    check("reset_outputs", obs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_state_idle", obs, '0);

    do_instr("r_add", O_R, 6'b100000, 0, 0);
    zf_force = 1;
    do_instr("beq_taken", O_BEQ, 6'b0, 0, 0);
    zf_force = 0;
    do_instr("beq_not_taken", O_BEQ, 6'b0, 0, 0);
    zf_force = -1;
    do_instr("lw_delay3", O_LW, 6'b0, 0, 3);
    do_instr("sw", O_SW, 6'b0, 1, 0);
    do_instr("jump", O_J, 6'b0, 0, 0);
    do_instr("fetch_timeout", O_R, 6'b100111, 9, 0);
    do_instr("fetch_ready_at_limit", O_R, 6'b101010, 8, 0);
    do_instr("lw_timeout", O_LW, 6'b0, 0, 20);
    do_instr("sw_timeout", O_SW, 6'b0, 2, 8);
    do_instr("illegal_opcode", 6'b111111, 6'b0, 0, 0);
    do_instr("illegal_funct", O_R, 6'b111111, 0, 0);
    do_instr("ori", O_ORI, 6'b0, 0, 0);
    do_instr("addi", O_ADDI, 6'b0, 0, 0);

    // Reset asserted while a store is waiting for memory
    cur_op = O_SW;
    cur_fn = 6'b0;
    model_instr(O_SW, 6'b0, 0, 20);
    run("rst_pre_store", 4);
    rst_n = 1'b0;
    #1;
    check("rst_async_drop", obs, '0);
    @(posedge clk);
    #1;
    check("rst_hold", obs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_idle", obs, '0);
    do_instr("after_reset", O_J, 6'b0, 0, 0);

    for (int k = 0; k < 150; k++) begin
      int kind;
      logic [5:0] op;
      logic [5:0] fn;
      kind = int'($urandom_range(0, 7));
      fn   = 6'($urandom);
      case (kind)
        0: op = O_LW;
        1: op = O_SW;
        2: begin op = O_R; fn = legal_fn[$urandom_range(0, 5)]; end
        3: op = O_R;
        4: op = O_BEQ;
        5: op = O_J;
        6: op = imm_ops[$urandom_range(0, 3)];
        default: op = 6'($urandom);
      endcase
      do_instr("random", op, fn, pick_delay(), pick_delay());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
